// File: rtl/hazard_stall_ctrl_if.sv
// D-stage decode inputs and hazard/forwarding outputs of hazard_stall_ctrl.
// master = decoder/pipeline side, slave = the stall controller.
interface hazard_stall_ctrl_if;
   logic [4:0] rs_D;
   logic [4:0] rt_D;
   logic       use_rs_D;
   logic       use_rt_D;
   logic [1:0] tuse_rs_D;
   logic [1:0] tuse_rt_D;
   logic [4:0] dst_D;
   logic [1:0] tnew_D;
   logic [1:0] md_start_D;
   logic       md_use_D;
   logic       flush;
   logic       stall;
   logic [4:0] addr_E;
   logic [4:0] addr_M;
   logic [4:0] addr_W;
   logic       md_busy;

   modport master (
      output rs_D, rt_D, use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D,
             dst_D, tnew_D, md_start_D, md_use_D, flush,
      input  stall, addr_E, addr_M, addr_W, md_busy
   );

   modport slave (
      input  rs_D, rt_D, use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D,
             dst_D, tnew_D, md_start_D, md_use_D, flush,
      output stall, addr_E, addr_M, addr_W, md_busy
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Tracks destination register and Tnew of the E/M/W instructions, drives the
// stage write-address buses for forwarding, raises the D-stage stall and
// runs the mult/div busy counter with exception-flush handling.
module hazard_stall_ctrl #(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10
) (
   input logic             clk,
   input logic             reset,
   hazard_stall_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      MD_NONE = 2'b00,
      MD_MULT = 2'b01,
      MD_DIV  = 2'b10,
      MD_RSVD = 2'b11
   } md_op_e;

   localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
   localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

   logic [4:0] dst_E, dst_M, dst_W;
   logic [1:0] tnew_E, tnew_M, tnew_W;
   logic [3:0] md_cnt;
   logic       md_in_E;

   md_op_e     md_op;
   logic       md_go;
   logic       haz_rs, haz_rt, haz_md;
   logic       stall_int;

   function automatic logic [1:0] dec_sat(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   assign md_op = md_op_e'(bus.md_start_D);
   assign md_go = !stall_int && ((md_op == MD_MULT) || (md_op == MD_DIV));

   // Data and mult/div hazard detection; W results are always forwardable.
   always_comb begin
      haz_rs = bus.use_rs_D && (bus.rs_D != 5'd0) &&
               (((bus.rs_D == dst_E) && (tnew_E > bus.tuse_rs_D)) ||
                ((bus.rs_D == dst_M) && (tnew_M > bus.tuse_rs_D)));
      haz_rt = bus.use_rt_D && (bus.rt_D != 5'd0) &&
               (((bus.rt_D == dst_E) && (tnew_E > bus.tuse_rt_D)) ||
                ((bus.rt_D == dst_M) && (tnew_M > bus.tuse_rt_D)));
      haz_md = bus.md_use_D && (md_cnt != 4'd0);
      stall_int = !bus.flush && (haz_rs || haz_rt || haz_md);
   end

   // Pipeline tracking registers and mult/div counter; flush beats stall/advance.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dst_E   <= '0;
         dst_M   <= '0;
         dst_W   <= '0;
         tnew_E  <= '0;
         tnew_M  <= '0;
         tnew_W  <= '0;
         md_cnt  <= '0;
         md_in_E <= 1'b0;
      end else if (bus.flush) begin
         dst_E   <= '0;
         dst_M   <= '0;
         dst_W   <= '0;
         tnew_E  <= '0;
         tnew_M  <= '0;
         tnew_W  <= '0;
         md_in_E <= 1'b0;
         // A start still sitting in E is cancelled; one already past E keeps counting.
         if (md_in_E)
            md_cnt <= '0;
         else if (md_cnt != 4'd0)
            md_cnt <= md_cnt - 4'd1;
      end else begin
         dst_W  <= dst_M;
         tnew_W <= dec_sat(tnew_M);
         dst_M  <= dst_E;
         tnew_M <= dec_sat(tnew_E);
         if (stall_int) begin
            dst_E  <= '0;
            tnew_E <= '0;
         end else begin
            dst_E  <= bus.dst_D;
            tnew_E <= bus.tnew_D;
         end
         md_in_E <= md_go;
         if (md_go)
            md_cnt <= (md_op == MD_DIV) ? DIV_LD : MULT_LD;
         else if (md_cnt != 4'd0)
            md_cnt <= md_cnt - 4'd1;
      end
   end

   // Forwarding addresses are only published once the result exists.
   always_comb begin
      bus.stall   = stall_int;
      bus.addr_E  = (tnew_E == 2'd0) ? dst_E : 5'd0;
      bus.addr_M  = (tnew_M == 2'd0) ? dst_M : 5'd0;
      bus.addr_W  = dst_W;
      bus.md_busy = (md_cnt != 4'd0);
   end

   logic unused_tnew_w;
   assign unused_tnew_w = ^tnew_W;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Producer-side partner of the pipeline forwarding logic. It tracks the destination register of every in-flight instruction and how many cycles remain until its result is ready (Tnew), for the E, M and W stages.
- It drives the stage write-address buses that the forwarding muxes consume, and raises the D-stage stall.
- It holds a multi-cycle mult/div busy counter and handles exception flush.
- Inputs arrive from the D-stage decoder, already decoded; outputs go to the pipeline registers and the forwarding controller.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu after entering E
- DIV_CYC, 10, busy cycles for div/divu after entering E

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- rs_D  in  5  D-stage rs index
- rt_D  in  5  D-stage rt index
- use_rs_D  in  1  D instruction reads rs
- use_rt_D  in  1  D instruction reads rt
- tuse_rs_D  in  2  cycles after D before rs is needed (0 = branch at D, 1 = ALU at E, 2 = store data at M)
- tuse_rt_D  in  2  same, for rt
- dst_D  in  5  destination register of the D instruction (0 = no write)
- tnew_D  in  2  cycles after entering E until the result exists (ALU = 1, load = 2, jal link = 0)
- md_start_D  in  2  00 none, 01 mult, 10 div, 11 reserved (treated as none)
- md_use_D  in  1  D instruction is mfhi/mflo/mthi/mtlo/mult/div
- flush  in  1  exception or eret taken at M this cycle
- stall  out  1  freeze PC and D; insert bubble into E
- addr_E  out  5  E destination; 0 unless Tnew_E == 0
- addr_M  out  5  M destination; 0 unless Tnew_M == 0
- addr_W  out  5  W destination (always ready)
- md_busy  out  1  mult/div unit busy

Behaviour:
- State: per stage X in {E, M, W}, a register pair dst_X[4:0] and tnew_X[1:0]. Also md_cnt[3:0] and md_in_E.
- Reset (reset == 0 at a clk edge):
  - all dst_X, tnew_X, md_cnt and md_in_E cleared.
  - stall = 0, addr_E/M/W = 0, md_busy = 0 from the next cycle.
- Advance on every edge unless reset or flush:
  - W ← M, with tnew saturating-decremented (max(t-1, 0)).
  - M ← E, with the same decrement.
  - E ← (dst_D, tnew_D) when stall == 0; E ← bubble (dst 0, tnew 0) when stall == 1.
- Flush has priority over stall and advance. E, M and W all become bubbles. The W instruction present during the flush cycle has already committed. Upstream replaces IR_D.
- Data-hazard stall (combinational). For src in {rs, rt}, stall when all of the following hold:
  - use_src_D is 1 and src_D != 0;
  - src_D == dst_E with tnew_E > tuse_src_D, or src_D == dst_M with tnew_M > tuse_src_D.
- W never causes a stall.
- Mult/div:
  - When an instruction with md_start_D != 0 moves D→E, md_cnt ← MULT_CYC or DIV_CYC and md_in_E ← 1. Otherwise md_in_E ← 0.
  - md_cnt decrements each cycle while nonzero.
  - md_busy = (md_cnt != 0).
  - Extra stall when md_use_D && md_busy.
- Flush while md_in_E == 1 clears md_cnt (the start is cancelled). A flush once the instruction has left E does not clear md_cnt.
- Address outputs are purely combinational from the state. A tracked dst of 0 always yields output 0.
- stall is the OR of the rs hazard, the rt hazard and the md hazard. It is forced to 0 while flush == 1.
- Widths: tnew saturates at 0 and never wraps. md_cnt is 4 bits and must hold DIV_CYC ≤ 15.

Test Plan:
1. lw $8 enters E (tnew 2); D is addu using rs = 8, tuse 1 → stall = 1 for 1 cycle, bubble in E. Next cycle the load is in M with tnew 1, stall = 0, addr_M = 0. One cycle later addr_W = 8.
2. addu $9 in E (tnew 1); D is beq reading $9 (tuse 0) → stall 1 cycle. Then addr_M = 9 and stall = 0.
3. addu $9 in E; D is sw with rt = 9 (tuse 2) → no stall. addr_E = 0 while tnew_E = 1; addr_M = 9 on the next cycle.
4. div enters E with DIV_CYC = 10; mflo in D → stall for exactly 10 cycles, md_busy high for 10 cycles, then both drop.
5. mult in E, then flush asserted the same cycle → md_busy = 0 and E/M/W bubbles next cycle. addr_E/M/W = 0 and stall = 0.
6. reset low for 1 edge mid-div with a load in M → all outputs 0 the next cycle and md_cnt = 0. With dst_D = 0 in flight, source 0 never stalls.
